// File: rtl/sterownik_nadawania.sv
`default_nettype none
// ---------------------------------------------------------------------------
// sterownik_nadawania: loads a word into a 4-bit bidirectional shift register
// and shifts it out serially. Optional parity bit: STEROWNIK_PARZYSTOSC_EN.
// Revision: 1.0
// ---------------------------------------------------------------------------
module sterownik_nadawania #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [WIDTH-1:0] DATA,
  input  logic             DIR,
  input  logic             VALID,
  output logic             READY,
  input  logic [WIDTH-1:0] Q,
  output logic [WIDTH-1:0] I,
  output logic             S1,
  output logic             S0,
  output logic             SER_OUT,
  output logic             SER_VALID,
  output logic             DONE
);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_SHIFT,
    ST_FIN
`ifdef STEROWNIK_PARZYSTOSC_EN
    , ST_PARITY
`endif
  } state_t;

  localparam logic [CNT_W-1:0] C_LAST = CNT_W'(WIDTH - 1);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] word_q, word_d;
  logic             dir_q, dir_d;
  logic             ready_q, ready_d;
  logic [1:0]       mode_q, mode_d;
  logic [WIDTH-1:0] i_q, i_d;
  logic             ser_valid_q, ser_valid_d;
  logic             done_q, done_d;
  logic             shifting_q, shifting_d;
  logic             parity_q, parity_d;
  logic [CNT_W-1:0] bit_idx;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    word_d  = word_q;
    dir_d   = dir_q;
    unique case (state_q)
      ST_IDLE: begin
        if (VALID) begin
          word_d  = DATA;
          dir_d   = DIR;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        state_d = ST_SHIFT;
        cnt_d   = '0;
      end
      ST_SHIFT: begin
        if (cnt_q == C_LAST) begin
          cnt_d = '0;
`ifdef STEROWNIK_PARZYSTOSC_EN
          state_d = ST_PARITY;
`else
          state_d = ST_FIN;
`endif
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
`ifdef STEROWNIK_PARZYSTOSC_EN
      ST_PARITY: state_d = ST_FIN;
`endif
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase

    // Outputs are decoded from the next state so they line up with state_q.
    ready_d     = (state_d == ST_IDLE);
    shifting_d  = (state_d == ST_SHIFT);
    done_d      = (state_d == ST_FIN);
    i_d         = (state_d == ST_LOAD) ? word_d : '0;
    mode_d      = 2'b00;
    if (state_d == ST_LOAD) begin
      mode_d = 2'b11;
    end else if (state_d == ST_SHIFT) begin
      mode_d = dir_d ? 2'b10 : 2'b01;
    end
`ifdef STEROWNIK_PARZYSTOSC_EN
    parity_d    = (state_d == ST_PARITY);
`else
    parity_d    = 1'b0;
`endif
    ser_valid_d = shifting_d | parity_d;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      word_q      <= '0;
      dir_q       <= 1'b0;
      ready_q     <= 1'b1;
      mode_q      <= 2'b00;
      i_q         <= '0;
      ser_valid_q <= 1'b0;
      done_q      <= 1'b0;
      shifting_q  <= 1'b0;
      parity_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      dir_q       <= dir_d;
      ready_q     <= ready_d;
      mode_q      <= mode_d;
      i_q         <= i_d;
      ser_valid_q <= ser_valid_d;
      done_q      <= done_d;
      shifting_q  <= shifting_d;
      parity_q    <= parity_d;
    end
  end

  // The exiting bit sits at the end the register shifts towards.
  assign bit_idx = dir_q ? C_LAST : '0;

  always_comb begin
    SER_OUT = 1'b0;
    if (shifting_q) begin
      SER_OUT = Q[bit_idx];
    end else if (parity_q) begin
      SER_OUT = ^word_q;
    end
  end

  assign READY     = ready_q;
  assign I         = i_q;
  assign S1        = mode_q[1];
  assign S0        = mode_q[0];
  assign SER_VALID = ser_valid_q;
  assign DONE      = done_q;

endmodule
`default_nettype wire
